// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Supplies a same-cycle next-PC prediction to fetch, is trained by ID-stage resolution and keeps saturating statistics.
module branch_predictor #(
  parameter int         AWIDTH   = 16,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] if_pc,
  output logic              pred_taken,
  output logic [AWIDTH-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [AWIDTH-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [AWIDTH-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [AWIDTH-1:0] upd_pred_next_pc,
  input  logic              inv_all,
  output logic              mispredict,
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = AWIDTH - 1 - IW;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tags    [ENTRIES];
  logic [AWIDTH-1:0]  targets [ENTRIES];
  logic [1:0]         ctrs    [ENTRIES];

  logic [IW-1:0]     lk_idx;
  logic [TW-1:0]     lk_tag;
  logic              lk_hit;
  logic [IW-1:0]     up_idx;
  logic [TW-1:0]     up_tag;
  logic              up_hit;
  logic [AWIDTH-1:0] actual_next;

  // The next-PC comparison alone decides a mispredict, so the carried direction flag is redundant.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  assign lk_idx = if_pc[IW:1];
  assign lk_tag = if_pc[AWIDTH-1:IW+1];
  assign lk_hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

  assign pred_taken   = lk_hit && ctrs[lk_idx][1];
  assign pred_next_pc = pred_taken ? targets[lk_idx] : if_pc + AWIDTH'(2);

  assign up_idx = upd_pc[IW:1];
  assign up_tag = upd_pc[AWIDTH-1:IW+1];
  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

  assign actual_next = upd_taken ? upd_target : upd_pc + AWIDTH'(2);
  assign mispredict  = upd_valid && (upd_pred_next_pc != actual_next);

  // Valid bits and counters; invalidate overrides any update presented with it.
  always_ff @(posedge clk) begin
    if (!rst || inv_all) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrs[i] <= CTR_INIT;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctrs[up_idx] != 2'b11) ctrs[up_idx] <= ctrs[up_idx] + 2'b01;
        end else begin
          if (ctrs[up_idx] != 2'b00) ctrs[up_idx] <= ctrs[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid[up_idx] <= 1'b1;
        ctrs[up_idx]  <= 2'b10;
      end
    end
  end

  // Tags and targets carry no reset; they only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (rst && !inv_all && upd_valid && upd_taken) begin
      tags[up_idx]    <= up_tag;
      targets[up_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && stat_branches != 16'hFFFF)
        stat_branches <= stat_branches + 16'd1;
      if (mispredict && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a behavioural table model kept in plain integer arrays.
module tb_branch_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc;
  logic        pred_taken;
  logic [15:0] pred_next_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_pred_taken;
  logic [15:0] upd_pred_next_pc;
  logic        inv_all;
  logic        mispredict;
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;

  int checks   = 0;
  int failures = 0;

  bit m_valid  [N];
  int m_tag    [N];
  int m_target [N];
  int m_ctr    [N];
  int m_br;
  int m_mp;

  branch_predictor #(.AWIDTH(16), .ENTRIES(N), .CTR_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_next_pc(upd_pred_next_pc), .inv_all(inv_all), .mispredict(mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(int pc);
    return (pc / 2) % N;
  endfunction

  function automatic int tag_of(int pc);
    return pc / (2 * N);
  endfunction

  function automatic bit m_hit(int pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic bit m_ptaken(int pc);
    return m_hit(pc) && m_ctr[idx_of(pc)] >= 2;
  endfunction

  function automatic int m_next(int pc);
    return m_ptaken(pc) ? m_target[idx_of(pc)] : (pc + 2) % 65536;
  endfunction

  function automatic bit m_misp();
    int actual;
    actual = upd_taken ? int'(upd_target) : (int'(upd_pc) + 2) % 65536;
    return upd_valid && int'(upd_pred_next_pc) != actual;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic idle();
    upd_valid = 1'b0; upd_taken = 1'b0; inv_all = 1'b0;
    upd_pc = 16'h0; upd_target = 16'h0;
    upd_pred_taken = 1'b0; upd_pred_next_pc = 16'h0;
  endtask

  // Present a resolved branch whose carried prediction is what the model would predict now.
  task automatic set_upd(input int pc, input bit taken, input int target);
    upd_valid = 1'b1; upd_pc = 16'(pc); upd_taken = taken; upd_target = 16'(target);
    upd_pred_taken = m_ptaken(pc); upd_pred_next_pc = 16'(m_next(pc));
  endtask

  task automatic settle_check();
    #1;
    check("pred_taken", {31'd0, pred_taken}, {31'd0, m_ptaken(int'(if_pc))});
    check("pred_next_pc", {16'd0, pred_next_pc}, 32'(m_next(int'(if_pc))));
    check("mispredict", {31'd0, mispredict}, {31'd0, m_misp()});
  endtask

  task automatic clock_edge(input bit chk);
    bit mp;
    int i;
    mp = m_misp();
    @(posedge clk);
    if (!rst) begin
      model_clear();
      m_br = 0; m_mp = 0;
    end else begin
      if (upd_valid && m_br < 65535) m_br++;
      if (mp && m_mp < 65535) m_mp++;
      if (inv_all) model_clear();
      else if (upd_valid) begin
        i = idx_of(int'(upd_pc));
        if (m_hit(int'(upd_pc))) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = int'(upd_target);
          end else m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end else if (upd_taken) begin
          m_valid[i] = 1'b1; m_tag[i] = tag_of(int'(upd_pc));
          m_target[i] = int'(upd_target); m_ctr[i] = 2;
        end
      end
    end
    #1;
    if (chk) begin
      check("stat_branches", {16'd0, stat_branches}, 32'(m_br));
      check("stat_mispredicts", {16'd0, stat_mispredicts}, 32'(m_mp));
    end
  endtask

  initial begin
    idle();
    rst = 1'b0; if_pc = 16'h0010;
    m_br = 0; m_mp = 0;
    model_clear();
    clock_edge(1'b0);
    rst = 1'b1;
    clock_edge(1'b1);

    // Cold lookups, including the wrap of the fall-through PC.
    settle_check();
    check("cold_taken", {31'd0, pred_taken}, 32'd0);
    check("cold_next", {16'd0, pred_next_pc}, 32'h0012);
    clock_edge(1'b1);
    if_pc = 16'hFFFE;
    settle_check();
    check("wrap_next", {16'd0, pred_next_pc}, 32'h0000);
    clock_edge(1'b1);

    // Allocate on a taken miss.
    if_pc = 16'h0010;
    upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0040;
    upd_pred_taken = 1'b0; upd_pred_next_pc = 16'h0012;
    settle_check();
    check("alloc_misp", {31'd0, mispredict}, 32'd1);
    clock_edge(1'b1);
    idle();
    settle_check();
    check("alloc_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_next", {16'd0, pred_next_pc}, 32'h0040);
    check("alloc_br", {16'd0, stat_branches}, 32'd1);
    check("alloc_mp", {16'd0, stat_mispredicts}, 32'd1);

    // Counter walk: 10 -> 01 -> 00 -> 00, then 01 -> 10 -> 11 -> 11.
    for (int k = 1; k <= 3; k++) begin
      set_upd(16'h0010, 1'b0, 16'h0040);
      settle_check();
      clock_edge(1'b1);
      idle();
      settle_check();
      check("sat_down_taken", {31'd0, pred_taken}, 32'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      set_upd(16'h0010, 1'b1, 16'h0040);
      settle_check();
      clock_edge(1'b1);
      idle();
      settle_check();
      check("sat_up_taken", {31'd0, pred_taken}, (k >= 2) ? 32'd1 : 32'd0);
    end

    // Aliasing on index 8.
    if_pc = 16'h0030;
    settle_check();
    check("alias_miss_next", {16'd0, pred_next_pc}, 32'h0032);
    set_upd(16'h0030, 1'b1, 16'h0100);
    clock_edge(1'b1);
    idle();
    if_pc = 16'h0010;
    settle_check();
    check("alias_evict_next", {16'd0, pred_next_pc}, 32'h0012);
    if_pc = 16'h0030;
    settle_check();
    check("alias_new_next", {16'd0, pred_next_pc}, 32'h0100);

    // Target-only mispredict.
    set_upd(16'h0010, 1'b1, 16'h0040);
    clock_edge(1'b1);
    upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0050;
    upd_pred_taken = 1'b1; upd_pred_next_pc = 16'h0040;
    if_pc = 16'h0010;
    settle_check();
    check("tgt_misp", {31'd0, mispredict}, 32'd1);
    clock_edge(1'b1);
    idle();
    settle_check();
    check("tgt_overwrite", {16'd0, pred_next_pc}, 32'h0050);

    // Randomized traffic over a small PC pool so hits, aliases and evictions all occur.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(63) != 0);
      if_pc = 16'({$urandom_range(3), 4'($urandom_range(15)), 1'b0});
      if ($urandom_range(3) != 0) begin
        set_upd(int'({$urandom_range(3), 4'($urandom_range(15)), 1'b0}),
                1'($urandom_range(1)), int'({$urandom_range(255), 1'b0}));
        if ($urandom_range(3) == 0) upd_pred_next_pc = 16'($urandom);
      end
      inv_all = ($urandom_range(31) == 0);
      settle_check();
      clock_edge(1'b1);
    end
    idle();
    rst = 1'b1;

    // Invalidate together with a taken update.
    set_upd(16'h0010, 1'b1, 16'h0040);
    clock_edge(1'b1);
    set_upd(16'h0020, 1'b1, 16'h0080);
    inv_all = 1'b1;
    clock_edge(1'b1);
    idle();
    for (int i = 0; i < N; i++) begin
      if_pc = 16'(i * 2 + 16'h0010 * (i % 2));
      settle_check();
      check("inv_taken", {31'd0, pred_taken}, 32'd0);
    end

    // Branch statistics saturate rather than wrap.
    set_upd(16'h0010, 1'b0, 16'h0040);
    for (int n = 0; n < 65536; n++) clock_edge(1'b0);
    check("sat_br", {16'd0, stat_branches}, 32'hFFFF);
    clock_edge(1'b1);
    check("sat_br_hold", {16'd0, stat_branches}, 32'hFFFF);

    // Mid-run reset with an update that must be discarded.
    set_upd(16'h0010, 1'b1, 16'h0040);
    clock_edge(1'b1);
    set_upd(16'h0044, 1'b1, 16'h0200);
    clock_edge(1'b1);
    set_upd(16'h0060, 1'b1, 16'h0300);
    rst = 1'b0;
    clock_edge(1'b1);
    rst = 1'b1;
    idle();
    check("rst_br", {16'd0, stat_branches}, 32'd0);
    check("rst_mp", {16'd0, stat_mispredicts}, 32'd0);
    foreach (m_valid[i]) begin
      if_pc = 16'(i * 2 + 16'h0040 * (i % 3));
      settle_check();
      check("rst_taken", {31'd0, pred_taken}, 32'd0);
    end
    if_pc = 16'h0060;
    settle_check();
    check("rst_discard", {16'd0, pred_next_pc}, 32'h0062);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
